// File: rtl/sync_down_divider_if.sv
// Bundle of load/count controls and count/pulse outputs for the down-counting rate divider.
// The slave modport is the divider; the master modport is whoever loads and consumes it.
interface sync_down_divider_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             cnten;
  logic             auto;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             busy;
  logic             tco;
  logic             sqo;

  modport master (
    output load,
    output din,
    output cnten,
    output auto,
    input  q,
    input  qb,
    input  busy,
    input  tco,
    input  sqo
  );

  modport slave (
    input  load,
    input  din,
    input  cnten,
    input  auto,
    output q,
    output qb,
    output busy,
    output tco,
    output sqo
  );
endinterface

// File: rtl/sync_down_divider.sv
// Loadable down-counter / programmable rate divider emitting a one-cycle TCO every N enabled cycles.
// Optional square-wave output SQO is built only when DDIV_SQUARE_EN is defined.
module sync_down_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_down_divider_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } divState_e;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  divState_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tco_q, tco_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tco_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tco_q    <= tco_d;
    end
  end

  // LOAD beats counting, so a load on the terminal cycle swallows that cycle's TCO.
  // A RUN count of 0 cannot occur; it is folded into the terminal branch defensively.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tco_d    = 1'b0;
    if (bus.load) begin
      reload_d = bus.din;
      count_d  = bus.din;
      state_d  = (bus.din != ZERO) ? RUN : IDLE;
    end else if ((state_q == RUN) && bus.cnten) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        tco_d = 1'b1;
        if (bus.auto) begin
          count_d = reload_q;
        end else begin
          count_d = ZERO;
          state_d = IDLE;
        end
      end
    end
  end

`ifdef DDIV_SQUARE_EN
  logic sqo_q, sqo_d;

  always_comb begin
    sqo_d = sqo_q ^ tco_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sqo_q <= 1'b0;
    end else begin
      sqo_q <= sqo_d;
    end
  end

  assign bus.sqo = sqo_q;
`else
  assign bus.sqo = 1'b0;
`endif

  assign bus.q    = count_q;
  assign bus.qb   = ~count_q;
  assign bus.busy = (state_q == RUN);
  assign bus.tco  = tco_q;

endmodule

// File: tb/tb_sync_down_divider.sv
// Directed-vector bench for sync_down_divider (WIDTH=8); expectations are hand-computed per scenario.
// Honours DDIV_SQUARE_EN so the SQO expectations follow the build.
module tb_sync_down_divider;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sync_down_divider_if #(.WIDTH(WIDTH)) bus ();

  sync_down_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string name, input logic [7:0] expQ,
                            input logic expBusy, input logic expTco);
    vectors++;
    if (bus.q !== expQ || bus.qb !== ~expQ || bus.busy !== expBusy || bus.tco !== expTco) begin
      miscompares++;
      $display("[TB] FAIL %s: got q=%0d qb=%h busy=%b tco=%b, want q=%0d qb=%h busy=%b tco=%b",
               name, bus.q, bus.qb, bus.busy, bus.tco, expQ, ~expQ, expBusy, expTco);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load = 1'b0; bus.din = '0; bus.cnten = 1'b0; bus.auto = 1'b0;
    #12;
    checkState("reset_idle", 8'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.sqo !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_sqo: got %b want 0", bus.sqo);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.load = 1'b1; bus.din = 8'd10; bus.auto = 1'b1; bus.cnten = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    checkState("pre_reset_run", 8'd8, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkState("async_reset_midrun", 8'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkState("no_tco_after_reset", 8'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] expQ [9] = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3};
    logic       expT [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.load = 1'b1; bus.din = 8'd4; bus.auto = 1'b1; bus.cnten = 1'b1;
    tick();
    bus.load = 1'b0;
    checkState("auto_load", 8'd4, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      checkState($sformatf("auto_step%0d", i), expQ[i], 1'b1, expT[i]);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] expQ [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       expB [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       expT [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.load = 1'b1; bus.din = 8'd3; bus.auto = 1'b0; bus.cnten = 1'b1;
    tick();
    bus.load = 1'b0;
    checkState("oneshot_load", 8'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkState($sformatf("oneshot_step%0d", i), expQ[i], expB[i], expT[i]);
    end
  endtask

  task automatic test_cnten_gating();
    logic       en   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] expQ [4] = '{8'd1, 8'd1, 8'd1, 8'd0};
    logic       expB [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       expT [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus.load = 1'b1; bus.din = 8'd2; bus.auto = 1'b0; bus.cnten = 1'b0;
    tick();
    bus.load = 1'b0;
    checkState("gate_load", 8'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.cnten = en[i];
      tick();
      checkState($sformatf("gate_step%0d", i), expQ[i], expB[i], expT[i]);
    end
  endtask

  task automatic test_boundaries();
    bus.load = 1'b1; bus.din = 8'd0; bus.auto = 1'b1; bus.cnten = 1'b1;
    tick();
    bus.load = 1'b0;
    checkState("load_zero", 8'd0, 1'b0, 1'b0);
    tick();
    checkState("load_zero_hold", 8'd0, 1'b0, 1'b0);

    bus.load = 1'b1; bus.din = 8'd2;
    tick();
    bus.load = 1'b0;
    checkState("coinc_load2", 8'd2, 1'b1, 1'b0);
    tick();
    checkState("coinc_q1", 8'd1, 1'b1, 1'b0);
    bus.load = 1'b1; bus.din = 8'd5;
    tick();
    bus.load = 1'b0;
    checkState("coinc_load_wins", 8'd5, 1'b1, 1'b0);
    tick();
    checkState("coinc_after", 8'd4, 1'b1, 1'b0);

    bus.load = 1'b1; bus.din = 8'd1; bus.auto = 1'b1;
    tick();
    bus.load = 1'b0;
    checkState("n1_load", 8'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkState($sformatf("n1_tco%0d", i), 8'd1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_square();
    logic expS;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.load = 1'b1; bus.din = 8'd3; bus.auto = 1'b1; bus.cnten = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef DDIV_SQUARE_EN
      expS = ((k / 3) % 2) == 1;
`else
      expS = 1'b0;
`endif
      vectors++;
      if (bus.sqo !== expS || bus.tco !== (k % 3 == 0)) begin
        miscompares++;
        $display("[TB] FAIL square_k%0d: got sqo=%b tco=%b want sqo=%b tco=%b",
                 k, bus.sqo, bus.tco, expS, (k % 3 == 0));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_cnten_gating();
    test_boundaries();
    test_square();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
